// File: rtl/shift_unit.sv
// Multi-cycle barrel-shifter replacement for the ARM shifter operand.
// Shifts up to STEP positions per cycle; result/carry_out latch on DONE.
module shift_unit #(
    parameter int STEP = 8
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [1:0]  op_form,
    input  logic [1:0]  shift_type,
    input  logic [31:0] amount,
    input  logic [31:0] value,
    input  logic        carry_in,
    output logic [31:0] result,
    output logic        carry_out,
    output logic        busy,
    output logic        done
);

    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

    localparam logic [2:0] K_LSL = 3'd0;
    localparam logic [2:0] K_LSR = 3'd1;
    localparam logic [2:0] K_ASR = 3'd2;
    localparam logic [2:0] K_ROR = 3'd3;
    localparam logic [2:0] K_RRX = 3'd4;
    localparam logic [5:0] STEP_N = 6'(STEP);

    state_t      state, state_nx;
    logic [31:0] work;
    logic        wc;
    logic [5:0]  rem;
    logic [2:0]  kind;
    logic        kill;

    logic [2:0]  d_kind;
    logic [5:0]  d_n;
    logic        d_c0;
    logic        d_kill;

    logic [5:0]  k;
    logic [5:0]  rem_nx;
    logic [32:0] lsl_t;
    logic [32:0] lsr_t;
    logic [32:0] asr_t;
    logic [31:0] ror_v;
    logic [31:0] s_w;
    logic        s_c;

    logic unused_amount;
    assign unused_amount = ^amount[31:8];

    // Decode the operand form into a uniform (kind, steps, carry) request.
    always_comb begin
        d_kind = K_ROR;
        d_n    = '0;
        d_c0   = carry_in;
        d_kill = 1'b0;
        unique case (op_form)
            2'b00: begin
                d_kind = K_ROR;
                d_n    = {1'b0, amount[3:0], 1'b0};
            end
            2'b01: begin
                d_kind = {1'b0, shift_type};
                d_n    = {1'b0, amount[4:0]};
                if (amount[4:0] == 5'd0) begin
                    if (shift_type == 2'b11) begin
                        d_kind = K_RRX;
                        d_n    = 6'd1;
                    end else if (shift_type != 2'b00) begin
                        d_n = 6'd32;
                    end
                end
            end
            2'b10: begin
                d_kind = {1'b0, shift_type};
                if (shift_type == 2'b11) begin
                    d_n = {1'b0, amount[4:0]};
                    if (amount[7:0] != 8'd0 && amount[4:0] == 5'd0)
                        d_c0 = value[31];
                end else if (amount[7:0] > 8'd32) begin
                    d_n    = 6'd32;
                    d_kill = (shift_type != 2'b10);
                end else begin
                    d_n = amount[5:0];
                end
            end
            default: ;
        endcase
    end

    assign k      = (rem > STEP_N) ? STEP_N : rem;
    assign rem_nx = rem - k;
    assign lsl_t  = {1'b0, work} << k;
    assign lsr_t  = {work, 1'b0} >> k;
    assign asr_t  = $signed({work, 1'b0}) >>> k;
    assign ror_v  = (work >> k) | (work << (6'd32 - k));

    always_comb begin
        s_w = work;
        s_c = wc;
        unique case (kind)
            K_LSL: begin s_w = lsl_t[31:0]; s_c = lsl_t[32]; end
            K_LSR: begin s_w = lsr_t[32:1]; s_c = lsr_t[0]; end
            K_ASR: begin s_w = asr_t[32:1]; s_c = asr_t[0]; end
            K_ROR: begin s_w = ror_v; s_c = ror_v[31]; end
            K_RRX: begin s_w = {wc, work[31:1]}; s_c = work[0]; end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        unique case (state)
            IDLE:  if (start) state_nx = (d_n == 6'd0) ? DONE : SHIFT;
            SHIFT: if (rem_nx == 6'd0) state_nx = DONE;
            DONE:  state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            result    <= '0;
            carry_out <= 1'b0;
            work      <= '0;
            wc        <= 1'b0;
            rem       <= '0;
            kind      <= K_LSL;
            kill      <= 1'b0;
        end else begin
            unique case (state)
                IDLE: if (start) begin
                    work <= value;
                    wc   <= d_c0;
                    rem  <= d_n;
                    kind <= d_kind;
                    kill <= d_kill;
                    if (d_n == 6'd0) begin
                        result    <= value;
                        carry_out <= d_c0;
                    end
                end
                SHIFT: begin
                    work <= s_w;
                    wc   <= s_c;
                    rem  <= rem_nx;
                    if (rem_nx == 6'd0) begin
                        result    <= s_w;
                        carry_out <= kill ? 1'b0 : s_c;
                    end
                end
                default: ;
            endcase
        end
    end

    assign busy = (state != IDLE);
    assign done = (state == DONE);

endmodule

// File: tb/tb_shift_unit.sv
// Randomized and directed bench for shift_unit against an arithmetic
// reference model of the ARM shifter-operand rules.
module tb_shift_unit;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [1:0]  op_form;
    logic [1:0]  shift_type;
    logic [31:0] amount;
    logic [31:0] value;
    logic        carry_in;
    logic [31:0] result;
    logic        carry_out;
    logic        busy;
    logic        done;

    int tests = 0;
    int fails = 0;
    int done_cnt = 0;

    shift_unit #(.STEP(8)) dut (
        .clk(clk), .reset(reset), .start(start),
        .op_form(op_form), .shift_type(shift_type),
        .amount(amount), .value(value), .carry_in(carry_in),
        .result(result), .carry_out(carry_out),
        .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    always @(posedge clk) if (done) done_cnt++;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] rotr(input logic [31:0] v, input int s);
        return (v >> s) | (v << (32 - s));
    endfunction

    // Plain shift by s in 1..32 for LSL/LSR/ASR, carry = last bit out.
    function automatic void std_shift(input logic [1:0] st,
                                      input logic [31:0] v, input int s,
                                      output logic [31:0] r,
                                      output logic c);
        logic [63:0] x, t;
        if (st == 2'b00) begin
            x = {32'b0, v};
            t = x << s;
            r = t[31:0];
            c = t[32];
        end else begin
            x = {v, 32'b0};
            if (st == 2'b01) t = x >> s;
            else             t = $signed(x) >>> s;
            r = t[63:32];
            c = t[31];
        end
    endfunction

    function automatic void model(input logic [1:0] op, input logic [1:0] st,
                                  input logic [31:0] amt,
                                  input logic [31:0] v, input logic cin,
                                  output logic [31:0] r, output logic c,
                                  output int n);
        int s;
        r = v;
        c = cin;
        n = 0;
        case (op)
            2'b00: begin
                s = 2 * int'(amt[3:0]);
                n = s;
                if (s != 0) begin r = rotr(v, s); c = r[31]; end
            end
            2'b01: begin
                s = int'(amt[4:0]);
                if (st == 2'b11) begin
                    if (s == 0) begin
                        r = {cin, v[31:1]}; c = v[0]; n = 1;
                    end else begin
                        r = rotr(v, s); c = r[31]; n = s;
                    end
                end else if (st == 2'b00 && s == 0) begin
                    n = 0;
                end else begin
                    if (s == 0) s = 32;
                    std_shift(st, v, s, r, c);
                    n = s;
                end
            end
            2'b10: begin
                s = int'(amt[7:0]);
                if (s != 0) begin
                    if (st == 2'b11) begin
                        if (s % 32 == 0) begin
                            c = v[31];
                        end else begin
                            n = s % 32;
                            r = rotr(v, n);
                            c = r[31];
                        end
                    end else if (s > 32) begin
                        n = 32;
                        if (st == 2'b10) begin
                            r = {32{v[31]}}; c = v[31];
                        end else begin
                            r = 0; c = 0;
                        end
                    end else begin
                        n = s;
                        std_shift(st, v, s, r, c);
                    end
                end
            end
            default: ;
        endcase
    endfunction

    task automatic do_op(input string name, input logic [1:0] op,
                         input logic [1:0] st, input logic [31:0] amt,
                         input logic [31:0] v, input logic cin,
                         input logic [31:0] er, input logic ec,
                         input int elat, input bit poke);
        int cyc;
        @(negedge clk);
        op_form = op; shift_type = st; amount = amt;
        value = v; carry_in = cin; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        cyc = 1;
        while (!done && cyc < 40) begin
            if (poke && busy) begin
                start = 1'b1;
                op_form = 2'($urandom); shift_type = 2'($urandom);
                amount = $urandom; value = $urandom;
                carry_in = 1'($urandom);
            end
            @(negedge clk);
            start = 1'b0;
            cyc++;
        end
        chk({name, ".lat"}, cyc, elat);
        chk({name, ".done"}, {31'b0, done}, 1);
        chk({name, ".result"}, result, er);
        chk({name, ".carry"}, {31'b0, carry_out}, {31'b0, ec});
        @(negedge clk);
        chk({name, ".idle"}, {30'b0, busy, done}, 0);
        chk({name, ".hold"}, result, er);
    endtask

    task automatic directed(input string name, input logic [1:0] op,
                            input logic [1:0] st, input logic [31:0] amt,
                            input logic [31:0] v, input logic cin,
                            input logic [31:0] er, input logic ec,
                            input int elat);
        logic [31:0] mr;
        logic        mc;
        int          mn;
        model(op, st, amt, v, cin, mr, mc, mn);
        chk({name, ".model_r"}, mr, er);
        chk({name, ".model_c"}, {31'b0, mc}, {31'b0, ec});
        chk({name, ".model_lat"}, (mn + 7) / 8 + 1, elat);
        do_op(name, op, st, amt, v, cin, er, ec, elat, 1'b0);
    endtask

    initial begin
        logic [1:0]  op, st;
        logic [31:0] amt, v, mr;
        logic        cin, mc;
        int          mn, prev;

        reset = 1'b1; start = 1'b0; op_form = '0; shift_type = '0;
        amount = '0; value = '0; carry_in = 1'b0;
        repeat (3) @(negedge clk);
        chk("reset.result", result, 0);
        chk("reset.flags", {29'b0, carry_out, busy, done}, 0);
        reset = 1'b0;

        directed("lsl4", 2'b10, 2'b00, 32'd4, 32'h8000_0001, 1'b0,
                 32'h0000_0010, 1'b0, 2);
        directed("lsr32", 2'b10, 2'b01, 32'd32, 32'h8000_0000, 1'b0,
                 32'h0, 1'b1, 5);
        directed("lsr33", 2'b10, 2'b01, 32'd33, 32'h8000_0000, 1'b1,
                 32'h0, 1'b0, 5);
        directed("rrx", 2'b01, 2'b11, 32'd0, 32'h0000_0003, 1'b1,
                 32'h8000_0001, 1'b1, 2);
        directed("rotimm", 2'b00, 2'b01, 32'hFFFF_FFF1, 32'h0000_00FF, 1'b0,
                 32'hC000_003F, 1'b1, 2);
        directed("asr40", 2'b10, 2'b10, 32'd40, 32'h8000_0000, 1'b0,
                 32'hFFFF_FFFF, 1'b1, 5);
        directed("asr0", 2'b10, 2'b10, 32'h0000_FF00, 32'h1234_5678, 1'b1,
                 32'h1234_5678, 1'b1, 1);
        directed("ror32", 2'b10, 2'b11, 32'd32, 32'h8000_0000, 1'b0,
                 32'h8000_0000, 1'b1, 1);
        directed("lsl0imm", 2'b01, 2'b00, 32'd0, 32'h0000_00F0, 1'b1,
                 32'h0000_00F0, 1'b1, 1);
        directed("lsr0imm", 2'b01, 2'b01, 32'd0, 32'h8000_0000, 1'b0,
                 32'h0, 1'b1, 5);
        directed("rsvd", 2'b11, 2'b01, 32'd9, 32'hDEAD_BEEF, 1'b1,
                 32'hDEAD_BEEF, 1'b1, 1);

        for (int i = 0; i < 300; i++) begin
            op = 2'($urandom_range(0, 3));
            st = 2'($urandom_range(0, 3));
            case ($urandom_range(0, 3))
                0: amt = $urandom;
                1: amt = $urandom_range(0, 40);
                2: amt = ($urandom & 32'hFFFF_FF00) | $urandom_range(0, 40);
                default: amt = $urandom_range(0, 255);
            endcase
            v = $urandom;
            cin = 1'($urandom);
            model(op, st, amt, v, cin, mr, mc, mn);
            do_op($sformatf("rnd%0d", i), op, st, amt, v, cin, mr, mc,
                  (mn + 7) / 8 + 1, 1'($urandom));
        end

        // Abort a long shift with reset; a second start while busy is ignored.
        prev = done_cnt;
        @(negedge clk);
        op_form = 2'b10; shift_type = 2'b00; amount = 32'd32;
        value = 32'hFFFF_FFFF; carry_in = 1'b1; start = 1'b1;
        @(negedge clk);
        op_form = 2'b11; start = 1'b1;
        chk("abort.busy", {31'b0, busy}, 1);
        @(negedge clk);
        start = 1'b0; reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        chk("abort.result", result, 0);
        chk("abort.flags", {29'b0, carry_out, busy, done}, 0);
        repeat (6) @(negedge clk);
        chk("abort.nodone", done_cnt, prev);

        @(negedge clk);
        reset = 1'b1; start = 1'b1; op_form = 2'b11;
        @(negedge clk);
        reset = 1'b0; start = 1'b0;
        chk("rststart.flags", {30'b0, busy, done}, 0);
        @(negedge clk);
        chk("rststart.nodone", done_cnt, prev);

        directed("recover", 2'b10, 2'b00, 32'd4, 32'h8000_0001, 1'b0,
                 32'h0000_0010, 1'b0, 2);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
